pc_fetch_unit: RTL and testbench

- Owns the program counter and the instruction fetch handshake for the multi-cycle KGP-RISC datapath.
- Consumes the per-instruction jump decision (validJump) and branch operands from the branch-resolution stage, computes the next PC, and fetches the next instruction from instruction memory over a req/ack handshake.
- Presents the fetched instruction, its PC and PC+4 (link value for bl) to decode/execute.

---
 rtl/pc_fetch_unit_pkg.sv | 13 +
 rtl/pc_fetch_unit_next_pc_calc.sv | 39 +++
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the KGP-RISC PC/fetch unit and its next-PC helper.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: fall-through, register target, or PC-relative label.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 26
) (
  input  logic [ADDR_W-1:0]       pc_i,
  input  logic                    valid_jump_i,
  input  logic                    jump_is_reg_i,
  input  logic signed [OFF_W-1:0] jump_offset_i,
  input  logic [ADDR_W-1:0]       reg_target_i,
  output logic [ADDR_W-1:0]       next_pc_o
);

  function automatic logic signed [ADDR_W-1:0] word_off_to_bytes(
    input logic signed [OFF_W-1:0] off
  );
    logic signed [ADDR_W-1:0] ext;
    ext = {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
    return ext <<< 2;
  endfunction

  logic [ADDR_W-1:0] seq_pc;

  // Label targets are relative to the fall-through address, not the branch itself.
  always_comb begin
    seq_pc    = pc_i + ADDR_W'(INSTR_BYTES);
    next_pc_o = seq_pc;
    if (valid_jump_i) begin
      if (jump_is_reg_i) begin
        next_pc_o = reg_target_i & ~ADDR_W'(INSTR_BYTES - 1);
      end else begin
        next_pc_o = seq_pc + word_off_to_bytes(jump_offset_i);
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch handshake for the multi-cycle KGP-RISC datapath.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                OFF_W    = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_jump,
  input  logic               jump_is_reg,
  input  logic [OFF_W-1:0]   jump_offset,
  input  logic [ADDR_W-1:0]  reg_target,
  input  logic               exec_done,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               halted
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic [ADDR_W-1:0]   next_pc;

  next_pc_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_next_pc (
    .pc_i          (pc_q),
    .valid_jump_i  (valid_jump),
    .jump_is_reg_i (jump_is_reg),
    .jump_offset_i (jump_offset),
    .reg_target_i  (reg_target),
    .next_pc_o     (next_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // An ack only counts while the request is actually up; the request is low
  // for the first cycle out of reset even though the state is already FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      FETCH: begin
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    req_d    = (state_d == FETCH);
    valid_d  = (state_d == EXEC);
    halted_d = (state_d == HALT);
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + ADDR_W'(INSTR_BYTES);
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, random run against a model, corner sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_jump, jump_is_reg, exec_done, halt, imem_ack;
  logic [25:0] jump_offset;
  logic [31:0] reg_target, imem_rdata;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .valid_jump  (valid_jump),
    .jump_is_reg (jump_is_reg),
    .jump_offset (jump_offset),
    .reg_target  (reg_target),
    .exec_done   (exec_done),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted)
  );

  typedef struct {
    logic [31:0] addr;
    logic        vj;
    logic        is_reg;
    logic [25:0] off;
    logic [31:0] rt;
    int          ack_dly;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Next PC from the ISA rules with plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic vj,
                                             input logic ir, input logic [25:0] off,
                                             input logic [31:0] rt);
    longint o;
    if (!vj) return p + 32'd4;
    if (ir) return rt - (rt % 32'd4);
    o = longint'($signed(off));
    return 32'(longint'(p) + 64'sd4 + o * 64'sd4);
  endfunction

  task automatic idle_inputs();
    valid_jump = 0; jump_is_reg = 0; jump_offset = '0; reg_target = '0;
    exec_done = 0; halt = 0; imem_ack = 0; imem_rdata = '0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !imem_req; k++) step();
    chk("fetch_req_seen", {63'd0, imem_req}, 64'd1);
  endtask

  // One full instruction: fetch at addr with ack_dly stall cycles, then execute
  // for exec_dly cycles while noise is on the jump/ack inputs, then resolve.
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] data,
                           input logic vj, input logic ir, input logic [25:0] off,
                           input logic [31:0] rt, input logic hlt,
                           input int ack_dly, input int exec_dly);
    wait_req();
    chk("fetch_addr", {32'd0, imem_addr}, {32'd0, addr});
    chk("fetch_valid_low", {63'd0, instr_valid}, 64'd0);
    for (int d = 0; d < ack_dly; d++) begin
      step();
      chk("stall_req", {63'd0, imem_req}, 64'd1);
      chk("stall_addr", {32'd0, imem_addr}, {32'd0, addr});
      chk("stall_valid", {63'd0, instr_valid}, 64'd0);
    end
    imem_ack = 1; imem_rdata = data;
    step();
    imem_ack = 0; imem_rdata = '0;
    chk("valid_after_ack", {63'd0, instr_valid}, 64'd1);
    chk("instr_latched", {32'd0, instr}, {32'd0, data});
    chk("pc_out", {32'd0, pc}, {32'd0, addr});
    chk("pc_plus4", {32'd0, pc_plus4}, {32'd0, addr + 32'd4});
    chk("req_low_exec", {63'd0, imem_req}, 64'd0);
    for (int d = 0; d < exec_dly; d++) begin
      valid_jump = 1'($urandom); jump_is_reg = 1'($urandom);
      jump_offset = 26'($urandom); reg_target = $urandom; halt = 1'($urandom);
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      step();
      chk("exec_hold_instr", {32'd0, instr}, {32'd0, data});
      chk("exec_hold_pc", {32'd0, pc}, {32'd0, addr});
      chk("exec_hold_valid", {63'd0, instr_valid}, 64'd1);
    end
    imem_ack = 0; imem_rdata = '0;
    exec_done = 1; halt = hlt; valid_jump = vj; jump_is_reg = ir;
    jump_offset = off; reg_target = rt;
    step();
    idle_inputs();
    if (!hlt) begin
      chk("req_after_done", {63'd0, imem_req}, 64'd1);
      chk("valid_drop", {63'd0, instr_valid}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] mpc, nxt, dat;
    logic        vj, ir;
    logic [25:0] off;
    logic [31:0] rt;

    tbl[0]  = '{32'h0000_0000, 0, 0, 26'h0,       32'h0,         1};
    tbl[1]  = '{32'h0000_0004, 0, 0, 26'h0,       32'h0,         1};
    tbl[2]  = '{32'h0000_0008, 1, 1, 26'h0,       32'h0000_0040, 0};
    tbl[3]  = '{32'h0000_0040, 1, 0, 26'h3FFFFFC, 32'h0,         2};
    tbl[4]  = '{32'h0000_0034, 1, 1, 26'h0,       32'h0000_1237, 5};
    tbl[5]  = '{32'h0000_1234, 1, 0, 26'h2,       32'h0,         0};
    tbl[6]  = '{32'h0000_1240, 1, 1, 26'h0,       32'hFFFF_FFFF, 1};
    tbl[7]  = '{32'hFFFF_FFFC, 0, 1, 26'h3,       32'h5555_5555, 0};
    tbl[8]  = '{32'h0000_0000, 1, 0, 26'h3FFFFFF, 32'h0,         3};
    tbl[9]  = '{32'h0000_0000, 0, 0, 26'h1000,    32'h0,         0};
    tbl[10] = '{32'h0000_0004, 1, 1, 26'h0,       32'h0000_0200, 1};
    tbl[11] = '{32'h0000_0200, 0, 0, 26'h0,       32'h0,         0};

    idle_inputs();
    rst = 0;
    step();
    step();
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_pc", {32'd0, pc}, 64'd0);
    chk("rst_pc_plus4", {32'd0, pc_plus4}, 64'd4);
    rst = 1;
    step();
    chk("req_first_edge", {63'd0, imem_req}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].addr, 32'hA500_0000 + 32'(i), tbl[i].vj, tbl[i].is_reg,
                tbl[i].off, tbl[i].rt, 1'b0, tbl[i].ack_dly, 2);
    end

    mpc = 32'h0000_0204;
    for (int i = 0; i < 40; i++) begin
      vj = 1'($urandom); ir = 1'($urandom);
      off = 26'($urandom); rt = $urandom; dat = $urandom;
      nxt = model_next(mpc, vj, ir, off, rt);
      run_instr(mpc, dat, vj, ir, off, rt, 1'b0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      mpc = nxt;
    end

    // Halt wins over a simultaneous jump and freezes the PC.
    run_instr(mpc, 32'hCAFE_F00D, 1'b1, 1'b1, 26'h0, 32'h0000_8000, 1'b1, 1, 1);
    chk("halted_set", {63'd0, halted}, 64'd1);
    chk("halt_req", {63'd0, imem_req}, 64'd0);
    chk("halt_valid", {63'd0, instr_valid}, 64'd0);
    chk("halt_pc", {32'd0, pc}, {32'd0, mpc});
    for (int d = 0; d < 4; d++) begin
      exec_done = 1; imem_ack = 1;
      step();
      chk("halt_stays", {63'd0, halted}, 64'd1);
      chk("halt_req_stays", {63'd0, imem_req}, 64'd0);
      chk("halt_pc_stays", {32'd0, pc}, {32'd0, mpc});
    end
    idle_inputs();

    // Reset release restarts from RESET_PC; then reset during a pending fetch.
    rst = 0;
    step();
    rst = 1;
    step();
    chk("restart_req", {63'd0, imem_req}, 64'd1);
    chk("restart_halted", {63'd0, halted}, 64'd0);
    run_instr(32'h0, 32'h1111_2222, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 0, 1);
    wait_req();
    chk("midrst_addr", {32'd0, imem_addr}, 64'h4);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    #2;
    rst = 0;
    #1;
    chk("midrst_req", {63'd0, imem_req}, 64'd0);
    chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
    chk("midrst_instr", {32'd0, instr}, 64'd0);
    chk("midrst_pc", {32'd0, pc}, 64'd0);
    step();
    chk("midrst_ack_drop", {32'd0, instr}, 64'd0);
    idle_inputs();
    rst = 1;
    step();
    chk("post_rst_req", {63'd0, imem_req}, 64'd1);
    chk("post_rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("post_rst_valid", {63'd0, instr_valid}, 64'd0);
    run_instr(32'h0, 32'h3333_4444, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 1, 0);
    wait_req();
    chk("post_rst_next", {32'd0, imem_addr}, 64'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
